// File: rtl/hd_encoder_pkg.sv
// -----------------------------------------------------------------------------
// hd_encoder_pkg
// Shared definitions for the spatial hyperdimensional encoder:
//   - encoder FSM state encoding
//   - ceil_log2 helper for deriving address/counter widths
//   - helpers that pull per-modality channel counts, base offsets, totals and
//     maxima out of the packed MOD_CHANNELS vector (32 bits per modality,
//     modality 0 in the LSBs). Callers zero-extend their vector to MC_BITS so
//     one function signature serves every modality count up to MAX_MODALITIES.
// -----------------------------------------------------------------------------
package hd_encoder_pkg;

    localparam int MAX_MODALITIES = 7;
    localparam int MC_BITS        = 32 * MAX_MODALITIES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAP    = 2'd1,
        ST_THRESH = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_e;

    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int mod_channels_of(input logic [MC_BITS-1:0] mc, input int m);
        return int'(mc[32*m +: 32]);
    endfunction

    // Global index of a modality's first channel: sum of all lower entries.
    function automatic int mod_base(input logic [MC_BITS-1:0] mc, input int m);
        int sum;
        sum = 0;
        for (int i = 0; i < MAX_MODALITIES; i++) begin
            if (i < m) begin
                sum = sum + int'(mc[32*i +: 32]);
            end
        end
        return sum;
    endfunction

    function automatic int total_channels(input logic [MC_BITS-1:0] mc);
        int sum;
        sum = 0;
        for (int i = 0; i < MAX_MODALITIES; i++) begin
            sum = sum + int'(mc[32*i +: 32]);
        end
        return sum;
    endfunction

    function automatic int max_channels(input logic [MC_BITS-1:0] mc);
        int mx;
        mx = 0;
        for (int i = 0; i < MAX_MODALITIES; i++) begin
            if (int'(mc[32*i +: 32]) > mx) begin
                mx = int'(mc[32*i +: 32]);
            end
        end
        return mx;
    endfunction

endpackage

// File: rtl/spatial_mod_accum.sv
// -----------------------------------------------------------------------------
// spatial_mod_accum
// One modality's bind-and-bundle engine. Walks its channels through a memory
// read handshake, binds item-memory HV with the sign-selected projection HV,
// counts ones per bit position and presents the thresholded modality HV.
// Optional feature macro: SPATIAL_TIEBREAK_EN (store channel 0/1 bound HVs and
// resolve ties with their XOR; otherwise ties resolve to 0).
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   clear_i             start of a new sample: clears counters, raises request
//   features_i          latched sample, channel 0 in MSBs
//   mem_req_o/addr_o    read request and global channel address
//   mem_valid_i         read data valid (consumed only while requesting)
//   mem_im_i/proj_*_i   item-memory and projection HVs
//   done_o              all channels of this modality consumed
//   mod_hv_o            thresholded modality HV
// -----------------------------------------------------------------------------
module spatial_mod_accum
    import hd_encoder_pkg::*;
#(
    parameter int HV_DIMENSION   = 2000,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int TOTAL_CHANNELS = 214,
    parameter int NUM_CH         = 32,
    parameter int BASE           = 0,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    clear_i,
    input  logic [TOTAL_CHANNELS*CHANNEL_WIDTH-1:0] features_i,
    input  logic                                    mem_valid_i,
    input  logic [HV_DIMENSION-1:0]                 mem_im_i,
    input  logic [HV_DIMENSION-1:0]                 mem_proj_neg_i,
    input  logic [HV_DIMENSION-1:0]                 mem_proj_pos_i,
    output logic                                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
    output logic                                    done_o,
    output logic [HV_DIMENSION-1:0]                 mod_hv_o
);

    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    req_q, req_d;
    logic [CNT_WIDTH-1:0]    bit_cnt_q [HV_DIMENSION];
    logic [CNT_WIDTH-1:0]    bit_cnt_d [HV_DIMENSION];
    logic                    fire_s;
    int                      sel_idx_s;
    logic [CHANNEL_WIDTH-1:0] feature_s;
    logic [HV_DIMENSION-1:0] bound_s;
    logic [CNT_WIDTH:0]      twice_s;
`ifdef SPATIAL_TIEBREAK_EN
    logic [HV_DIMENSION-1:0] tie0_q, tie0_d, tie1_q, tie1_d;
`endif

    assign fire_s     = req_q & mem_valid_i;
    assign mem_req_o  = req_q;
    assign done_o     = done_q;
    assign mem_addr_o = ADDR_WIDTH'(BASE + int'(cnt_q));

    // Current channel's feature and its bound HV; the index is clamped once
    // cnt has stepped past the last channel so the select stays in range.
    always_comb begin
        sel_idx_s = BASE;
        if (cnt_q < CNT_WIDTH'(NUM_CH)) begin
            sel_idx_s = BASE + int'(cnt_q);
        end else begin
            sel_idx_s = BASE;
        end
        feature_s = features_i[(TOTAL_CHANNELS - 1 - sel_idx_s) * CHANNEL_WIDTH +: CHANNEL_WIDTH];
        bound_s   = mem_im_i ^ (feature_s[CHANNEL_WIDTH-1] ? mem_proj_neg_i : mem_proj_pos_i);
    end

    // Next-state for channel counter, done flag, request and bit counters.
    always_comb begin
        cnt_d     = cnt_q;
        done_d    = done_q;
        req_d     = req_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SPATIAL_TIEBREAK_EN
        tie0_d    = tie0_q;
        tie1_d    = tie1_q;
`endif
        if (clear_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
            req_d  = 1'b1;
            for (int b = 0; b < HV_DIMENSION; b++) begin
                bit_cnt_d[b] = '0;
            end
        end else if (fire_s) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            for (int b = 0; b < HV_DIMENSION; b++) begin
                bit_cnt_d[b] = bit_cnt_q[b] + {{(CNT_WIDTH-1){1'b0}}, bound_s[b]};
            end
            if (cnt_q == CNT_WIDTH'(NUM_CH - 1)) begin
                done_d = 1'b1;
                req_d  = 1'b0;
            end else begin
                done_d = done_q;
            end
`ifdef SPATIAL_TIEBREAK_EN
            if (cnt_q == CNT_WIDTH'(0)) begin
                tie0_d = bound_s;
            end else if (cnt_q == CNT_WIDTH'(1)) begin
                tie1_d = bound_s;
            end else begin
                tie0_d = tie0_q;
            end
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Threshold each bit count against half the channel count.
    always_comb begin
        mod_hv_o = '0;
        twice_s  = '0;
        for (int b = 0; b < HV_DIMENSION; b++) begin
            twice_s = {bit_cnt_q[b], 1'b0};
            if (twice_s > (CNT_WIDTH+1)'(NUM_CH)) begin
                mod_hv_o[b] = 1'b1;
            end else if (twice_s == (CNT_WIDTH+1)'(NUM_CH)) begin
`ifdef SPATIAL_TIEBREAK_EN
                mod_hv_o[b] = tie0_q[b] ^ tie1_q[b];
`else
                mod_hv_o[b] = 1'b0;
`endif
            end else begin
                mod_hv_o[b] = 1'b0;
            end
        end
    end

    // State registers for this modality.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            req_q  <= 1'b0;
            for (int b = 0; b < HV_DIMENSION; b++) begin
                bit_cnt_q[b] <= '0;
            end
`ifdef SPATIAL_TIEBREAK_EN
            tie0_q <= '0;
            tie1_q <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            req_q     <= req_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SPATIAL_TIEBREAK_EN
            tie0_q    <= tie0_d;
            tie1_q    <= tie1_d;
`endif
        end
    end

endmodule

// File: rtl/spatial_encoder_multimod.sv
// -----------------------------------------------------------------------------
// spatial_encoder_multimod
// Multi-modality hyperdimensional spatial encoder. Latches one sample, runs
// one spatial_mod_accum per modality in parallel, then fuses the modality HVs
// by bitwise majority into a registered output HV with valid/ready handshake.
// Optional feature macro: SPATIAL_TIEBREAK_EN (tie resolution in the
// per-modality threshold, see spatial_mod_accum).
// Ports:
//   Clk_CI, Reset_RI                  clock, async active-high reset
//   ValidIn_SI/ReadyOut_SO            input sample handshake
//   ChannelsInput_DI                  signed features, channel 0 in MSBs
//   ValidOut_SO/ReadyIn_SI            output HV handshake
//   HypervectorOut_DO                 fused spatial HV
//   MemReq_SO/MemAddr_DO/MemValid_SI  per-modality memory read handshake
//   MemIM_DI/MemProjNeg_DI/MemProjPos_DI  per-modality memory read data
//   Busy_SO                           high whenever not IDLE
// -----------------------------------------------------------------------------
module spatial_encoder_multimod
    import hd_encoder_pkg::*;
#(
    parameter int HV_DIMENSION   = 2000,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int NUM_MODALITIES = 3,
    parameter logic [32*NUM_MODALITIES-1:0] MOD_CHANNELS = {32'd105, 32'd77, 32'd32},
    localparam logic [MC_BITS-1:0] MC_EXT = MC_BITS'(MOD_CHANNELS),
    localparam int TOTAL_CHANNELS = total_channels(MC_EXT),
    localparam int MAX_CHANNELS   = max_channels(MC_EXT),
    localparam int ADDR_WIDTH     = ceil_log2(TOTAL_CHANNELS),
    localparam int CNT_WIDTH      = ceil_log2(MAX_CHANNELS + 1)
) (
    input  logic                                     Clk_CI,
    input  logic                                     Reset_RI,
    input  logic                                     ValidIn_SI,
    output logic                                     ReadyOut_SO,
    input  logic [TOTAL_CHANNELS*CHANNEL_WIDTH-1:0]  ChannelsInput_DI,
    output logic                                     ValidOut_SO,
    input  logic                                     ReadyIn_SI,
    output logic [HV_DIMENSION-1:0]                  HypervectorOut_DO,
    output logic [NUM_MODALITIES-1:0]                MemReq_SO,
    output logic [NUM_MODALITIES*ADDR_WIDTH-1:0]     MemAddr_DO,
    input  logic [NUM_MODALITIES-1:0]                MemValid_SI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   MemIM_DI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   MemProjNeg_DI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   MemProjPos_DI,
    output logic                                     Busy_SO
);

    enc_state_e                              state_q, state_d;
    logic [TOTAL_CHANNELS*CHANNEL_WIDTH-1:0] features_q, features_d;
    logic [HV_DIMENSION-1:0]                 hv_q, hv_d, fused_s;
    logic                                    valid_q, valid_d;
    logic                                    ready_q, ready_d;
    logic                                    busy_q, busy_d;
    logic                                    clear_s;
    logic [NUM_MODALITIES-1:0]               done_s;
    logic [HV_DIMENSION-1:0]                 mod_hv_s [NUM_MODALITIES];
    logic [3:0]                              votes_s;

    assign ReadyOut_SO       = ready_q;
    assign ValidOut_SO       = valid_q;
    assign Busy_SO           = busy_q;
    assign HypervectorOut_DO = hv_q;

    // Per-modality engines.
    for (genvar m = 0; m < NUM_MODALITIES; m++) begin : g_mod
        spatial_mod_accum #(
            .HV_DIMENSION  (HV_DIMENSION),
            .CHANNEL_WIDTH (CHANNEL_WIDTH),
            .TOTAL_CHANNELS(TOTAL_CHANNELS),
            .NUM_CH        (mod_channels_of(MC_EXT, m)),
            .BASE          (mod_base(MC_EXT, m)),
            .ADDR_WIDTH    (ADDR_WIDTH),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_accum (
            .clk_i         (Clk_CI),
            .rst_i         (Reset_RI),
            .clear_i       (clear_s),
            .features_i    (features_q),
            .mem_valid_i   (MemValid_SI[m]),
            .mem_im_i      (MemIM_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .mem_proj_neg_i(MemProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .mem_proj_pos_i(MemProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .mem_req_o     (MemReq_SO[m]),
            .mem_addr_o    (MemAddr_DO[m*ADDR_WIDTH +: ADDR_WIDTH]),
            .done_o        (done_s[m]),
            .mod_hv_o      (mod_hv_s[m])
        );
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ValidIn_SI) state_d = ST_MAP;
                else            state_d = ST_IDLE;
            end
            ST_MAP: begin
                if (&done_s) state_d = ST_THRESH;
                else         state_d = ST_MAP;
            end
            ST_THRESH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ReadyIn_SI) state_d = ST_IDLE;
                else            state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bitwise majority over the modality HVs (modality count is odd).
    always_comb begin
        fused_s = '0;
        votes_s = 4'd0;
        for (int b = 0; b < HV_DIMENSION; b++) begin
            votes_s = 4'd0;
            for (int m = 0; m < NUM_MODALITIES; m++) begin
                votes_s = votes_s + {3'd0, mod_hv_s[m][b]};
            end
            fused_s[b] = (votes_s > 4'(NUM_MODALITIES / 2));
        end
    end

    // Datapath next-state; status outputs are derived from the next state so
    // they come straight off flops.
    always_comb begin
        clear_s    = (state_q == ST_IDLE) && ValidIn_SI;
        features_d = clear_s ? ChannelsInput_DI : features_q;
        hv_d       = (state_q == ST_THRESH) ? fused_s : hv_q;
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        valid_d    = (state_d == ST_DONE);
    end

    // Top-level registers.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q    <= ST_IDLE;
            features_q <= '0;
            hv_q       <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            features_q <= features_d;
            hv_q       <= hv_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_spatial_encoder_multimod.sv
// -----------------------------------------------------------------------------
// tb_spatial_encoder_multimod
// Self-checking bench: 3 modalities with 4/3/2 channels, 16-bit HVs. A
// behavioural memory answers each modality's address; a reference model
// computes the fused HV directly from features and memory contents.
// -----------------------------------------------------------------------------
module tb_spatial_encoder_multimod;

    localparam int HV  = 16;
    localparam int CW  = 8;
    localparam int NM  = 3;
    localparam int TOT = 9;
    localparam int AW  = 4;
    localparam int LAT = 6;
    localparam int MODN [NM] = '{4, 3, 2};
    localparam logic [32*NM-1:0] MODC = {32'd2, 32'd3, 32'd4};

    logic              Clk_CI;
    logic              Reset_RI;
    logic              ValidIn_SI;
    logic              ReadyOut_SO;
    logic [TOT*CW-1:0] ChannelsInput_DI;
    logic              ValidOut_SO;
    logic              ReadyIn_SI;
    logic [HV-1:0]     HypervectorOut_DO;
    logic [NM-1:0]     MemReq_SO;
    logic [NM*AW-1:0]  MemAddr_DO;
    logic [NM-1:0]     MemValid_SI;
    logic [NM*HV-1:0]  MemIM_DI;
    logic [NM*HV-1:0]  MemProjNeg_DI;
    logic [NM*HV-1:0]  MemProjPos_DI;
    logic              Busy_SO;

    int            feat_a [TOT];
    logic [HV-1:0] im_mem [TOT];
    logic [HV-1:0] pn_mem [TOT];
    logic [HV-1:0] pp_mem [TOT];
    logic [NM-1:0] mem_valid;
    bit            rand_stall;
    int            vec_count;
    int            fail_count;

    spatial_encoder_multimod #(
        .HV_DIMENSION  (HV),
        .CHANNEL_WIDTH (CW),
        .NUM_MODALITIES(NM),
        .MOD_CHANNELS  (MODC)
    ) dut (
        .Clk_CI           (Clk_CI),
        .Reset_RI         (Reset_RI),
        .ValidIn_SI       (ValidIn_SI),
        .ReadyOut_SO      (ReadyOut_SO),
        .ChannelsInput_DI (ChannelsInput_DI),
        .ValidOut_SO      (ValidOut_SO),
        .ReadyIn_SI       (ReadyIn_SI),
        .HypervectorOut_DO(HypervectorOut_DO),
        .MemReq_SO        (MemReq_SO),
        .MemAddr_DO       (MemAddr_DO),
        .MemValid_SI      (MemValid_SI),
        .MemIM_DI         (MemIM_DI),
        .MemProjNeg_DI    (MemProjNeg_DI),
        .MemProjPos_DI    (MemProjPos_DI),
        .Busy_SO          (Busy_SO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    assign MemValid_SI = mem_valid;

    // Memory: returns the entries of whatever channel each modality addresses.
    always_comb begin
        MemIM_DI      = '0;
        MemProjNeg_DI = '0;
        MemProjPos_DI = '0;
        for (int m = 0; m < NM; m++) begin
            if (MemAddr_DO[m*AW +: AW] < AW'(TOT)) begin
                MemIM_DI[m*HV +: HV]      = im_mem[MemAddr_DO[m*AW +: AW]];
                MemProjNeg_DI[m*HV +: HV] = pn_mem[MemAddr_DO[m*AW +: AW]];
                MemProjPos_DI[m*HV +: HV] = pp_mem[MemAddr_DO[m*AW +: AW]];
            end
        end
    end

    // Random per-modality read stalls when enabled.
    always @(negedge Clk_CI) begin
        if (rand_stall) mem_valid = NM'($urandom);
    end

    // Reference: bind, per-modality majority with tie rule, then fused majority.
    function automatic logic [HV-1:0] model_hv();
        logic [HV-1:0] bound [TOT];
        logic [HV-1:0] mod_bits [NM];
        logic [HV-1:0] res;
        int base, ones, votes;
        for (int c = 0; c < TOT; c++) begin
            bound[c] = im_mem[c] ^ ((feat_a[c] < 0) ? pn_mem[c] : pp_mem[c]);
        end
        base = 0;
        for (int m = 0; m < NM; m++) begin
            for (int b = 0; b < HV; b++) begin
                ones = 0;
                for (int k = 0; k < MODN[m]; k++) ones += int'(bound[base+k][b]);
                if (2*ones > MODN[m]) mod_bits[m][b] = 1'b1;
                else if (2*ones == MODN[m]) begin
`ifdef SPATIAL_TIEBREAK_EN
                    mod_bits[m][b] = bound[base][b] ^ bound[base+1][b];
`else
                    mod_bits[m][b] = 1'b0;
`endif
                end
                else mod_bits[m][b] = 1'b0;
            end
            base += MODN[m];
        end
        for (int b = 0; b < HV; b++) begin
            votes = 0;
            for (int m = 0; m < NM; m++) votes += int'(mod_bits[m][b]);
            res[b] = (2*votes > NM);
        end
        return res;
    endfunction

    task automatic load_features();
        for (int c = 0; c < TOT; c++) begin
            ChannelsInput_DI[(TOT-1-c)*CW +: CW] = CW'(feat_a[c]);
        end
    endtask

    task automatic randomize_sample();
        for (int c = 0; c < TOT; c++) begin
            feat_a[c] = int'($urandom_range(0, 255)) - 128;
            im_mem[c] = HV'($urandom);
            pn_mem[c] = HV'($urandom);
            pp_mem[c] = HV'($urandom);
        end
        load_features();
    endtask

    // Present a sample for one clock; returns #1 after the accepting edge.
    task automatic drive_accept();
        @(negedge Clk_CI);
        ValidIn_SI = 1'b1;
        @(posedge Clk_CI);
        #1;
        ValidIn_SI = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk_CI);
            #1;
            cyc++;
            if (ValidOut_SO) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_output();
        ReadyIn_SI = 1'b1;
        @(posedge Clk_CI);
        #1;
        ReadyIn_SI = 1'b0;
    endtask

    task automatic test_reset();
        Reset_RI   = 1'b1;
        ValidIn_SI = 1'b0;
        ReadyIn_SI = 1'b0;
        rand_stall = 1'b0;
        mem_valid  = '1;
        ChannelsInput_DI = '0;
        for (int c = 0; c < TOT; c++) begin
            feat_a[c] = 0; im_mem[c] = '0; pn_mem[c] = '0; pp_mem[c] = '0;
        end
        repeat (2) @(posedge Clk_CI);
        #1;
        vec_count++;
        if ({ReadyOut_SO, ValidOut_SO, Busy_SO, MemReq_SO} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
            fail_count++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b req=%b, want 1 0 0 000",
                     ReadyOut_SO, ValidOut_SO, Busy_SO, MemReq_SO);
        end
        vec_count++;
        if (HypervectorOut_DO !== 16'h0000) begin
            fail_count++;
            $display("FAIL reset_hv: got %h want 0000", HypervectorOut_DO);
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
    endtask

    task automatic test_latency_pos();
        int cyc; bit ok;
        for (int c = 0; c < TOT; c++) begin
            feat_a[c] = 1; im_mem[c] = 16'hF0F0; pp_mem[c] = 16'h0F0F; pn_mem[c] = 16'h1234;
        end
        load_features();
        drive_accept();
        vec_count++;
        if ({Busy_SO, ReadyOut_SO} !== 2'b10) begin
            fail_count++;
            $display("FAIL busy_after_accept: got busy=%b rdy=%b want 1 0", Busy_SO, ReadyOut_SO);
        end
        wait_valid(cyc, ok);
        vec_count++;
        if (!ok || cyc !== LAT) begin
            fail_count++;
            $display("FAIL latency: got %0d cycles (seen=%b) want %0d", cyc, ok, LAT);
        end
        vec_count++;
        if (HypervectorOut_DO !== 16'hFFFF) begin
            fail_count++;
            $display("FAIL pos_hv: got %h want ffff", HypervectorOut_DO);
        end
        release_output();
    endtask

    task automatic test_async_reset();
        int cyc; bit ok;
        randomize_sample();
        drive_accept();
        @(posedge Clk_CI);
        #3;
        Reset_RI = 1'b1;
        #1;
        vec_count++;
        if ({ReadyOut_SO, ValidOut_SO, Busy_SO, MemReq_SO, HypervectorOut_DO} !==
            {1'b1, 1'b0, 1'b0, 3'b000, 16'h0000}) begin
            fail_count++;
            $display("FAIL async_reset: got rdy=%b vld=%b busy=%b req=%b hv=%h want 1 0 0 000 0000",
                     ReadyOut_SO, ValidOut_SO, Busy_SO, MemReq_SO, HypervectorOut_DO);
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        randomize_sample();
        drive_accept();
        wait_valid(cyc, ok);
        vec_count++;
        if (!ok || HypervectorOut_DO !== model_hv()) begin
            fail_count++;
            $display("FAIL after_reset_hv: got %h (seen=%b) want %h", HypervectorOut_DO, ok, model_hv());
        end
        release_output();
    endtask

    task automatic test_neg_stall();
        int cyc; bit ok;
        for (int c = 0; c < TOT; c++) begin
            feat_a[c] = -1; im_mem[c] = 16'hF0F0; pn_mem[c] = 16'hF0F0; pp_mem[c] = 16'h0F0F;
        end
        load_features();
        drive_accept();
        wait_valid(cyc, ok);
        vec_count++;
        if (!ok || HypervectorOut_DO !== 16'h0000) begin
            fail_count++;
            $display("FAIL neg_hv: got %h (seen=%b) want 0000", HypervectorOut_DO, ok);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk_CI);
            #1;
            vec_count++;
            if ({ValidOut_SO, HypervectorOut_DO} !== {1'b1, 16'h0000}) begin
                fail_count++;
                $display("FAIL hold_%0d: got vld=%b hv=%h want 1 0000", i, ValidOut_SO, HypervectorOut_DO);
            end
        end
        release_output();
        vec_count++;
        if ({ValidOut_SO, ReadyOut_SO} !== 2'b01) begin
            fail_count++;
            $display("FAIL after_release: got vld=%b rdy=%b want 0 1", ValidOut_SO, ReadyOut_SO);
        end
    endtask

    task automatic test_tie();
        int cyc; bit ok;
        logic [HV-1:0] want;
`ifdef SPATIAL_TIEBREAK_EN
        want = 16'hFFFF;
`else
        want = 16'h0000;
`endif
        for (int c = 0; c < TOT; c++) begin
            feat_a[c] = 1; im_mem[c] = 16'h0000; pn_mem[c] = 16'h5A5A;
        end
        pp_mem[0] = 16'hFFFF; pp_mem[1] = 16'h0000; pp_mem[2] = 16'hFFFF; pp_mem[3] = 16'h0000;
        pp_mem[4] = 16'hFFFF; pp_mem[5] = 16'hFFFF; pp_mem[6] = 16'hFFFF;
        pp_mem[7] = 16'h0000; pp_mem[8] = 16'h0000;
        load_features();
        drive_accept();
        wait_valid(cyc, ok);
        vec_count++;
        if (!ok || HypervectorOut_DO !== want) begin
            fail_count++;
            $display("FAIL tie_hv: got %h (seen=%b) want %h", HypervectorOut_DO, ok, want);
        end
        release_output();
    endtask

    task automatic test_stall_mod1();
        int cyc; bit ok;
        randomize_sample();
        drive_accept();
        mem_valid = 3'b111;
        @(posedge Clk_CI);
        #1;
        mem_valid = 3'b101;
        for (int i = 0; i < 7; i++) begin
            vec_count++;
            if ({MemReq_SO[1], MemAddr_DO[7:4]} !== {1'b1, 4'd5}) begin
                fail_count++;
                $display("FAIL stall_addr_%0d: got req=%b addr=%0d want 1 5", i, MemReq_SO[1], MemAddr_DO[7:4]);
            end
            @(posedge Clk_CI);
            #1;
        end
        vec_count++;
        if ({MemReq_SO, Busy_SO} !== {3'b010, 1'b1}) begin
            fail_count++;
            $display("FAIL stall_others: got req=%b busy=%b want 010 1", MemReq_SO, Busy_SO);
        end
        mem_valid = 3'b111;
        wait_valid(cyc, ok);
        vec_count++;
        if (!ok || HypervectorOut_DO !== model_hv()) begin
            fail_count++;
            $display("FAIL stall_hv: got %h (seen=%b) want %h", HypervectorOut_DO, ok, model_hv());
        end
        release_output();
    endtask

    task automatic test_random();
        int cyc; bit ok;
        rand_stall = 1'b1;
        for (int s = 0; s < 200; s++) begin
            randomize_sample();
            drive_accept();
            // Junk sample offered while busy must be ignored.
            ChannelsInput_DI = {TOT{8'($urandom)}};
            ValidIn_SI = 1'($urandom);
            wait_valid(cyc, ok);
            ValidIn_SI = 1'b0;
            vec_count++;
            if (!ok || HypervectorOut_DO !== model_hv()) begin
                fail_count++;
                $display("FAIL rand_hv_%0d: got %h (seen=%b) want %h", s, HypervectorOut_DO, ok, model_hv());
            end
            vec_count++;
            if ({ReadyOut_SO, Busy_SO} !== 2'b01) begin
                fail_count++;
                $display("FAIL rand_done_%0d: got rdy=%b busy=%b want 0 1", s, ReadyOut_SO, Busy_SO);
            end
            release_output();
        end
        rand_stall = 1'b0;
        mem_valid  = '1;
    endtask

    initial begin
        vec_count  = 0;
        fail_count = 0;
        test_reset();
        test_latency_pos();
        test_async_reset();
        test_neg_stall();
        test_tie();
        test_stall_mod1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule

// File: doc/spatial_encoder_multimod.md
Name: spatial_encoder_multimod

Overview:
Parametrised hyperdimensional spatial encoder for N-modality sensor fusion. It latches one sample of TOTAL_CHANNELS signed features. It then binds each channel's item-memory HV with a sign-selected projection HV, fetched over per-modality memory handshakes. Per-modality bundling runs in parallel by bitwise counting plus thresholding, and the modality HVs are fused by bitwise majority. Output feeds the temporal encoder through a valid/ready handshake.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits
CHANNEL_WIDTH, 8, signed two's-complement feature width
NUM_MODALITIES, 3, modality count; must be odd, 1..7
MOD_CHANNELS, {32'd105,32'd77,32'd32}, packed 32 bits per modality, modality 0 in LSBs; each entry >= 2
TOTAL_CHANNELS, derived, sum of MOD_CHANNELS
MAX_CHANNELS, derived, largest MOD_CHANNELS entry
ADDR_WIDTH, derived, ceilLog2(TOTAL_CHANNELS)
CNT_WIDTH, derived, ceilLog2(MAX_CHANNELS+1)

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  reset
ValidIn_SI  in  1  input sample valid
ReadyOut_SO  out  1  encoder can accept a sample
ChannelsInput_DI  in  TOTAL_CHANNELS*CHANNEL_WIDTH  features, channel 0 in MSBs
ValidOut_SO  out  1  fused HV valid
ReadyIn_SI  in  1  downstream ready
HypervectorOut_DO  out  HV_DIMENSION  fused spatial HV
MemReq_SO  out  NUM_MODALITIES  per-modality read request
MemAddr_DO  out  NUM_MODALITIES*ADDR_WIDTH  global channel index per modality
MemValid_SI  in  NUM_MODALITIES  read data valid, same cycle as request
MemIM_DI  in  NUM_MODALITIES*HV_DIMENSION  item-memory HV
MemProjNeg_DI  in  NUM_MODALITIES*HV_DIMENSION  negative projection HV
MemProjPos_DI  in  NUM_MODALITIES*HV_DIMENSION  positive projection HV
Busy_SO  out  1  high in any state except IDLE
Clock is Clk_CI. Reset_RI is asynchronous and active-high; one clock domain.

Behaviour:
- Reset values: state IDLE, all counters/accumulators/flags 0, HypervectorOut_DO 0, ValidOut_SO 0, MemReq_SO 0, Busy_SO 0, ReadyOut_SO 1.
- FSM states and transitions:
  - IDLE: ReadyOut_SO=1. ValidIn_SI registers the features and goes to MAP.
  - MAP: go to THRESH when all modalities' done flags are set.
  - THRESH: go to DONE unconditionally.
  - DONE: ValidOut_SO=1. ReadyIn_SI goes to IDLE. HV is held stable while stalled.
- MAP, per modality m (independent, parallel):
  - MemReq_SO[m]=1 while done[m]=0.
  - MemAddr_DO[m] = base_m + cnt_m, where base_m = sum of MOD_CHANNELS below m.
  - On a cycle with MemValid_SI[m]=1:
    - bound = IM ^ (feature<0 ? ProjNeg : ProjPos).
    - Each bit counter += bound bit.
    - cnt_m++.
    - When cnt_m = MOD_CHANNELS[m]-1 is consumed, set done[m]. MemReq_SO[m] drops the next cycle.
  - MemValid_SI[m]=0 stalls modality m only.
  - Mem inputs are ignored when MemReq_SO[m]=0.
- THRESH: modality bit = 1 if 2*count > MOD_CHANNELS[m]; tie resolved per Optional Feature. Fused bit = majority over the modality bits, registered into HypervectorOut_DO.
- Latency, all MemValid_SI high: ValidIn accept -> ValidOut_SO = MAX_CHANNELS+2 cycles.
- Counters are CNT_WIDTH wide and never overflow. Counters and done flags clear on the IDLE->MAP transition.
- ValidIn_SI outside IDLE is ignored, with no buffering.
- Reset mid-MAP or mid-DONE aborts the sample. A pending output is discarded.

Optional Feature:
SPATIAL_TIEBREAK_EN
- Defined: bound HVs of the modality's channels 0 and 1 are stored. On a tie (2*count == MOD_CHANNELS[m]), the bit = bound0 ^ bound1.
- Undefined: a tie resolves to 0, and no storage registers exist.

Decomposition:
- Package hd_encoder_pkg: ceilLog2 function, FSM state encoding, modality offset/base function computed from MOD_CHANNELS.
- Sub-module spatial_mod_accum, instanced NUM_MODALITIES times. It owns cnt_m, done[m], bit counters, tiebreak storage and threshold output.
- Fusion majority and FSM live in the top.

Test Plan:
- HV_DIMENSION=8, MOD_CHANNELS={3,3,3}, all features +1, every channel IM=8'hF0, ProjPos=8'h0F -> bound 8'hFF per channel, HypervectorOut_DO=8'hFF; ValidOut_SO 5 cycles after accept.
- Same setup, features -1, ProjNeg=8'hF0 -> bound 8'h00, output 8'h00. Then hold ReadyIn_SI=0 for 10 cycles -> ValidOut_SO and the HV stay constant.
- MOD_CHANNELS={4,2,2}, modality 0 with two bound HVs 8'hFF and two 8'h00 (tie) -> modality 0 bits = ch0^ch1 = 8'hFF with SPATIAL_TIEBREAK_EN, 8'h00 without.
- MemValid_SI[1] low for 7 cycles mid-MAP -> only modality 1 stalls; MemAddr_DO[1] holds; result matches the no-stall golden model.
- Assert Reset_RI asynchronously between clock edges during MAP -> all outputs at reset values immediately; next sample encodes correctly.
- Random features, NUM_MODALITIES=5, default widths, 200 samples -> bit-exact vs software golden model.
